// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and line levels for the UART TX frame controller
// Purpose: one definition of the frame FSM states and the serial line levels,
//          used by uart_tx_ctrl and its testbench.
// Ports:   none (package).
package uart_tx_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - byte handshake and serial line bundle for the UART TX frame controller
// Purpose: groups the upstream byte handshake and the TX line outputs.
// Signals: P_Data     parallel byte to send
//          Data_Valid P_Data valid (taken only while Busy=0)
//          Par_En     frame carries a parity bit (sampled at acceptance)
//          Par_bit    registered parity bit from the parity calculator
//          TX_OUT     serial line, idle high
//          Busy       frame in progress
// Modports: master = upstream/driver side, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if #(
   parameter int Data_Width = 8
) ();

   logic [Data_Width-1:0] P_Data;
   logic                  Data_Valid;
   logic                  Par_En;
   logic                  Par_bit;
   logic                  TX_OUT;
   logic                  Busy;

   modport master (
      output P_Data, Data_Valid, Par_En, Par_bit,
      input  TX_OUT, Busy
   );

   modport slave (
      input  P_Data, Data_Valid, Par_En, Par_bit,
      output TX_OUT, Busy
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - data shift register and bit counter for the UART TX frame controller
// Purpose: holds the accepted byte, presents it LSB first and counts data bits.
// Ports:   clk_i       clock
//          rst_ni      asynchronous active-low reset
//          load_i      latch data_i and clear the bit counter
//          data_i      byte to latch
//          shift_i     shift right by one (ser_data_o is the bit shifted out)
//          cnt_en_i    advance the bit counter
//          ser_data_o  current LSB of the shift register
//          ser_done_o  counter is on the last data bit
module uart_tx_serializer #(
   parameter int Data_Width = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [Data_Width-1:0] data_i,
   input  logic                  shift_i,
   input  logic                  cnt_en_i,
   output logic                  ser_data_o,
   output logic                  ser_done_o
);

   localparam int CNT_W = $clog2(Data_Width);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Data_Width - 1);

   logic [Data_Width-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   assign ser_data_o = shift_q[0];
   assign ser_done_o = (cnt_q == CNT_LAST);

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shift_d = data_i;
         cnt_d   = '0;
      end else begin
         if (shift_i) begin
            shift_d = {1'b0, shift_q[Data_Width-1:1]};
         end
         // Holding at the last index keeps power-of-two widths from wrapping.
         if (cnt_en_i && !ser_done_o) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART TX frame controller: start, LSB-first data, optional parity, stop
// Purpose: accepts a byte when idle and drives one frame on the serial line.
//          Optional Tx_Done_o pulse is built only with UART_TX_DONE_EN defined.
// Ports:   clk_i      clock, one bit time per cycle
//          rst_ni     asynchronous active-low reset
//          tx_if      uart_tx_ctrl_if.slave (P_Data, Data_Valid, Par_En, Par_bit in;
//                     TX_OUT, Busy out)
//          Tx_Done_o  one-cycle pulse during the stop bit (UART_TX_DONE_EN only)
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int Data_Width = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   uart_tx_ctrl_if.slave tx_if
`ifdef UART_TX_DONE_EN
   ,
   output logic          Tx_Done_o
`endif
);

   tx_state_e state_q, state_d;
   logic      tx_q, tx_d;
   logic      busy_q, busy_d;
   logic      par_en_q, par_en_d;
   logic      accept;
   logic      shift_en;
   logic      cnt_en;
   logic      ser_data;
   logic      ser_done;

   assign accept = (state_q == IDLE) && tx_if.Data_Valid && !busy_q;

   // Shifting on every edge that lands in DATA means the pre-shift LSB is
   // exactly the bit registered onto the line for the coming cycle.
   assign shift_en = (state_d == DATA);
   assign cnt_en   = (state_q == DATA);

   uart_tx_serializer #(
      .Data_Width (Data_Width)
   ) u_ser (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (accept),
      .data_i     (tx_if.P_Data),
      .shift_i    (shift_en),
      .cnt_en_i   (cnt_en),
      .ser_data_o (ser_data),
      .ser_done_o (ser_done)
   );

   always_comb begin
      state_d  = state_q;
      par_en_d = par_en_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = START;
               par_en_d = tx_if.Par_En;
            end
         end
         START:   state_d = DATA;
         DATA: begin
            if (ser_done) begin
               state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY:  state_d = STOP;
         STOP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs decode the next state so the registered line matches the state register.
      tx_d   = IDLE_LEVEL;
      busy_d = 1'b1;
      case (state_d)
         IDLE:    busy_d = 1'b0;
         START:   tx_d   = START_LEVEL;
         DATA:    tx_d   = ser_data;
         PARITY:  tx_d   = tx_if.Par_bit;
         STOP:    tx_d   = STOP_LEVEL;
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         tx_q     <= IDLE_LEVEL;
         busy_q   <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         par_en_q <= par_en_d;
      end
   end

   assign tx_if.TX_OUT = tx_q;
   assign tx_if.Busy   = busy_q;

`ifdef UART_TX_DONE_EN
   logic done_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (state_d == STOP);
      end
   end

   assign Tx_Done_o = done_q;
`endif

endmodule
